// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between N_REQ message sources.
// Ownership is held for a whole message; priority rotates after each completed message.
module tx_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 7
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_dados,
  input  logic [N_REQ-1:0]        req_ultimo,
  input  logic                    tx_pronto,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        char_ack,
  output logic [N_REQ-1:0]        msg_fim,
  output logic                    tx_partida,
  output logic [DATA_W-1:0]       tx_dados,
  output logic                    ocupado
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [2:0] {StIdle, StLock, StStart, StWait, StAck} state_e;

  state_e            state_q, state_d;
  idx_t              owner_q, owner_d;
  idx_t              last_q, last_d;
  logic [DATA_W-1:0] dados_q, dados_d;
  logic              ultimo_q, ultimo_d;
  idx_t              pick;
  logic              pick_vld;
  int unsigned       rr_idx;

  // Scan last+1, last+2, ... modulo N_REQ; first requester found wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      rr_idx = int'(last_q) + k;
      if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
      if (!pick_vld && req[idx_t'(rr_idx)]) begin
        pick     = idx_t'(rr_idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    dados_d    = dados_q;
    ultimo_d   = ultimo_q;
    grant      = '0;
    char_ack   = '0;
    msg_fim    = '0;
    tx_partida = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          owner_d = pick;
          state_d = StLock;
        end
      end
      StLock: begin
        dados_d  = req_dados[owner_q*DATA_W +: DATA_W];
        ultimo_d = req_ultimo[owner_q];
        // A dropped request aborts here, only between characters.
        state_d  = req[owner_q] ? StStart : StIdle;
      end
      StStart: begin
        tx_partida = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        if (tx_pronto) state_d = StAck;
      end
      StAck: begin
        char_ack[owner_q] = 1'b1;
        if (ultimo_q) begin
          msg_fim[owner_q] = 1'b1;
          last_d           = owner_q;
          state_d          = StIdle;
        end else begin
          state_d = StLock;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) grant[owner_q] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      last_q   <= idx_t'(N_REQ - 1);
      dados_q  <= '0;
      ultimo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      dados_q  <= dados_d;
      ultimo_q <= ultimo_d;
    end
  end

  assign ocupado  = (state_q != StIdle);
  assign tx_dados = dados_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios with literal expectations, then randomized
// requester traffic checked every cycle against a behavioural transaction model.
module tb_tx_arbiter;

  localparam int N = 3;
  localparam int W = 7;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_dados = '0;
  logic [N-1:0]   req_ultimo = '0;
  logic           tx_pronto = 1'b0;
  logic [N-1:0]   grant, char_ack, msg_fim;
  logic           tx_partida, ocupado;
  logic [W-1:0]   tx_dados;

  tx_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .req_dados  (req_dados),
    .req_ultimo (req_ultimo),
    .tx_pronto  (tx_pronto),
    .grant      (grant),
    .char_ack   (char_ack),
    .msg_fim    (msg_fim),
    .tx_partida (tx_partida),
    .tx_dados   (tx_dados),
    .ocupado    (ocupado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: owner (-1 when free), step within a character transfer
  // (0 = data latch, 1 = start pulse, 2 = waiting on transmitter, 3 = acknowledge).
  int       m_owner, m_step, m_last, m_txd;
  bit       m_ult;
  bit [N-1:0] p_ack, p_fim;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] e_ack();
    return (m_owner >= 0 && m_step == 3) ? onehot(m_owner) : '0;
  endfunction

  function automatic logic [N-1:0] e_fim();
    return (m_owner >= 0 && m_step == 3 && m_ult) ? onehot(m_owner) : '0;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_step  = 0;
    m_last  = N - 1;
    m_txd   = 0;
    m_ult   = 0;
    p_ack   = '0;
    p_fim   = '0;
  endfunction

  function automatic void model_step();
    bit found;
    p_ack = e_ack();
    p_fim = e_fim();
    if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_step  = 0;
          found   = 1;
        end
      end
    end else if (m_step == 0) begin
      m_txd = int'(req_dados[m_owner*W +: W]);
      m_ult = req_ultimo[m_owner];
      if (!req[m_owner]) m_owner = -1;
      else m_step = 1;
    end else if (m_step == 1) begin
      m_step = 2;
    end else if (m_step == 2) begin
      if (tx_pronto) m_step = 3;
    end else begin
      if (m_ult) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_step = 0;
      end
    end
  endfunction

  function automatic void compare_all();
    check("grant", 32'(grant), 32'(onehot(m_owner)));
    check("ocupado", 32'(ocupado), 32'(m_owner >= 0));
    check("tx_partida", 32'(tx_partida), 32'(m_owner >= 0 && m_step == 1));
    check("char_ack", 32'(char_ack), 32'(e_ack()));
    check("msg_fim", 32'(msg_fim), 32'(e_fim()));
    check("tx_dados", 32'(tx_dados), 32'(m_txd));
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n    = 1'b0;
    req        = '0;
    req_ultimo = '0;
    req_dados  = '0;
    tx_pronto  = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Random requester agents.
  bit         act [N];
  int         len [N];
  int         pos [N];
  logic [W-1:0] msg [N][4];

  task automatic drive_agents();
    for (int i = 0; i < N; i++) begin
      req[i]             = act[i];
      req_dados[i*W +: W] = msg[i][pos[i]];
      req_ultimo[i]      = (pos[i] == len[i] - 1);
    end
  endtask

  initial begin
    logic [N-1:0] order [4];
    int           n_grants, idle_run, fims;
    bit           prev_busy;

    // Reset state and one-character message from requester 0.
    do_reset();
    #1;
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_tx_dados", 32'(tx_dados), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    req = 3'b001; req_ultimo = 3'b001; req_dados[0 +: W] = 7'h41;
    tick();
    check("t1_lock_grant", 32'(grant), 32'h1);
    check("t1_lock_partida", 32'(tx_partida), 32'd0);
    tick();
    check("t1_partida", 32'(tx_partida), 32'd1);
    check("t1_tx_dados", 32'(tx_dados), 32'h41);
    repeat (4) tick();
    tx_pronto = 1'b1;
    tick();
    check("t1_char_ack", 32'(char_ack), 32'h1);
    check("t1_msg_fim", 32'(msg_fim), 32'h1);
    req = '0; tx_pronto = 1'b0;
    tick();
    check("t1_idle", 32'(ocupado), 32'd0);

    // Requester 1 sends "OK"; tx_pronto held high also covers START ignoring it.
    req = 3'b010; req_ultimo = 3'b000; req_dados[1*W +: W] = 7'h4F; tx_pronto = 1'b1;
    tick();
    check("t2_grant", 32'(grant), 32'h2);
    tick();
    check("t2_dados_o", 32'(tx_dados), 32'h4F);
    check("t2_partida_o", 32'(tx_partida), 32'd1);
    tick();
    check("t2_wait_noack", 32'(char_ack), 32'd0);
    tick();
    check("t2_ack_o", 32'(char_ack), 32'h2);
    check("t2_nofim_o", 32'(msg_fim), 32'd0);
    req_ultimo = 3'b010; req_dados[1*W +: W] = 7'h4B;
    tick();
    tick();
    check("t2_dados_k", 32'(tx_dados), 32'h4B);
    check("t2_grant_k", 32'(grant), 32'h2);
    tick();
    tick();
    check("t2_fim_k", 32'(msg_fim), 32'h2);
    req = '0; tx_pronto = 1'b0;
    tick();

    // All three requesting one-character messages continuously.
    do_reset();
    req = 3'b111; req_ultimo = 3'b111; tx_pronto = 1'b1;
    n_grants = 0; idle_run = 0; prev_busy = 0;
    for (int c = 0; c < 40 && n_grants < 4; c++) begin
      tick();
      if (ocupado && !prev_busy) begin
        order[n_grants] = grant;
        if (n_grants > 0) check("t3_idle_gap", 32'(idle_run), 32'd1);
        n_grants++;
        idle_run = 0;
      end else if (!ocupado) begin
        idle_run++;
      end
      prev_busy = ocupado;
    end
    check("t3_grant_count", 32'(n_grants), 32'd4);
    if (n_grants == 4) begin
      check("t3_order0", 32'(order[0]), 32'h1);
      check("t3_order1", 32'(order[1]), 32'h2);
      check("t3_order2", 32'(order[2]), 32'h4);
      check("t3_order3", 32'(order[3]), 32'h1);
    end
    req = '0; tx_pronto = 1'b0;

    // After requester 0's message, req=101 must go to requester 2.
    do_reset();
    req = 3'b001; req_ultimo = 3'b001; tx_pronto = 1'b1;
    repeat (4) tick();
    check("t4_ack0", 32'(char_ack), 32'h1);
    req = 3'b101; req_ultimo = 3'b101;
    tick();
    tick();
    check("t4_grant2", 32'(grant), 32'h4);
    req = '0;
    repeat (4) tick();

    // Owner drops req during WAIT of a non-last character.
    do_reset();
    req = 3'b001; req_ultimo = 3'b000; req_dados[0 +: W] = 7'h21;
    repeat (3) tick();
    req = '0; tx_pronto = 1'b1;
    tick();
    check("t5_ack", 32'(char_ack), 32'h1);
    check("t5_nofim", 32'(msg_fim), 32'd0);
    tx_pronto = 1'b0;
    tick();
    check("t5_lock_nopartida", 32'(tx_partida), 32'd0);
    tick();
    check("t5_idle", 32'(ocupado), 32'd0);
    check("t5_idle_nopartida", 32'(tx_partida), 32'd0);

    // Asynchronous reset during WAIT.
    do_reset();
    req = 3'b001; req_ultimo = 3'b001; req_dados[0 +: W] = 7'h33;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_ocupado", 32'(ocupado), 32'd0);
    check("t6_rst_dados", 32'(tx_dados), 32'd0);
    model_reset();
    req = 3'b010; req_ultimo = 3'b010; req_dados[1*W +: W] = 7'h55; tx_pronto = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("t6_grant1", 32'(grant), 32'h2);
    tick();
    check("t6_dados", 32'(tx_dados), 32'h55);
    tick();
    tick();
    check("t6_fim", 32'(msg_fim), 32'h2);
    req = '0;
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 0; len[i] = 1; pos[i] = 0;
      for (int j = 0; j < 4; j++) msg[i][j] = '0;
    end
    fims = 0;
    for (int c = 0; c < 3000; c++) begin
      drive_agents();
      tx_pronto = ($urandom_range(0, 3) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        if (p_fim[i]) begin
          act[i] = 0;
          fims++;
        end else if (p_ack[i]) begin
          pos[i]++;
        end
        if (!act[i] && $urandom_range(0, 9) == 0) begin
          act[i] = 1;
          len[i] = $urandom_range(1, 4);
          pos[i] = 0;
          for (int j = 0; j < 4; j++) msg[i][j] = W'($urandom);
        end else if (act[i] && $urandom_range(0, 199) == 0) begin
          act[i] = 0;
        end
      end
    end
    check("rand_msgs_done", 32'(fims > 50), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares the single serial transmitter (tx_partida / tx_dados / tx_pronto) between N_REQ message sources, e.g. the play analyser, the score reporter and the debug dumper.
- Each source sends a multi-character message one character at a time. The arbiter grants the transmitter for a whole message, then rotates priority round-robin.
- Sits between the control units that produce characters and the serial TX datapath.

Parameters:
- N_REQ, 3, number of requesters (2..4 supported).
- DATA_W, 7, character width sent to the transmitter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester message request (level).
- req_dados  in  N_REQ*DATA_W  current character of each requester; requester i uses bits [i*DATA_W +: DATA_W].
- req_ultimo  in  N_REQ  current character is the last of its message.
- tx_pronto  in  1  transmitter finished current character (pulse or level).
- grant  out  N_REQ  one-hot; requester owning the transmitter.
- char_ack  out  N_REQ  1-cycle pulse to the owner after its character is sent.
- msg_fim  out  N_REQ  1-cycle pulse to the owner when its message completes.
- tx_partida  out  1  1-cycle start pulse to the transmitter.
- tx_dados  out  DATA_W  registered character presented to the transmitter.
- ocupado  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - tx_dados=0; all outputs 0.
  - A reset in any state aborts the transfer immediately; no ack/fim pulse is emitted.
- States and transitions:
  - IDLE: if any req is set, pick the first set bit scanning last_grant+1, +2, … modulo N_REQ; register the owner; go to LOCK. Otherwise stay.
  - LOCK: tx_dados <= owner's req_dados; ultimo_r <= owner's req_ultimo. If owner's req=0, go to IDLE with no pulses. Otherwise go to START.
  - START: tx_partida=1 for exactly this cycle; go to WAIT. tx_pronto is ignored in START.
  - WAIT: stay until tx_pronto=1, then go to ACK.
  - ACK: char_ack[owner]=1. If ultimo_r: msg_fim[owner]=1, last_grant<=owner, go to IDLE. Else go to LOCK.
- Output decode:
  - grant[owner]=1 in LOCK, START, WAIT and ACK; 0 in IDLE.
  - ocupado = (state != IDLE).
  - tx_dados holds its value until the next LOCK.
- Latency:
  - req seen in IDLE at cycle t: LOCK at t+1, tx_partida at t+2.
  - Per character overhead beyond the transmitter time: LOCK + START + ACK = 3 cycles.
- Requester contract:
  - Advance to the next character on the clock edge where char_ack is high; the new data is sampled in the following LOCK.
  - Hold req high for the whole message.
- Boundaries:
  - Owner drops req mid-message: abort only at the next LOCK. A transmission in flight completes and is acked.
  - Other requesters changing req during a message: no effect until IDLE.
  - Single requester holding req continuously: served back-to-back. IDLE lasts 1 cycle between messages.
  - Simultaneous requests: strict round-robin at message granularity; no starvation.
  - One-character message (req_ultimo=1 on first char): char_ack and msg_fim in the same ACK cycle.

Test Plan:
- Reset, then req=001, req_ultimo=1, char 0x41; tx_pronto 5 cycles after tx_partida -> tx_partida at t+2, tx_dados=0x41, char_ack[0] and msg_fim[0] together, back to IDLE.
- Requester 1 sends "OK" (0x4F, then 0x4B with ultimo=1) -> two tx_partida pulses, tx_dados sequence 0x4F, 0x4B, grant=010 throughout, one msg_fim[1].
- req=111 held continuously, 1-char messages -> grant order 001, 010, 100, 001; ocupado low exactly 1 cycle between messages.
- req=101 after a message from requester 0 -> requester 2 is granted next.
- Owner drops req while in WAIT of a non-last character -> char_ack pulses, then IDLE with no msg_fim and no further tx_partida.
- reset_n asserted low during WAIT -> outputs 0 asynchronously; after release, req=010 is served with the requester 0 priority pointer restored.
